// File: rtl/serial_frame_sched.sv
// serial_frame_sched: two-requester arbiter driving a 40-cycle serial command/read frame
//   clk, rst_n         : clock, asynchronous active-low reset
//   req0/req1, cmd0/1  : level requests with 7-bit command words, held until ack
//   dq_in              : serial read data from the target
//   count40            : frame cycle counter 0..39
//   dq_out             : serial command bit, two cycles per bit, MSB first
//   ack0/ack1          : one-cycle grant pulse at count40==39
//   busy               : current frame carries a granted transaction
//   rdata/rvalid/rid   : completed read word, its one-cycle strobe and owner
module serial_frame_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [6:0] cmd0,
    input  logic [6:0] cmd1,
    input  logic       dq_in,
    output logic [5:0] count40,
    output logic       dq_out,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic [9:0] rdata,
    output logic       rvalid,
    output logic       rid
);
    logic [5:0] cnt_q, cnt_d;
    logic       busy_q, busy_d, own_q, own_d, nxt_q, nxt_d, rid_q, rid_d;
    logic [6:0] cmd_q, cmd_d;
    logic [8:0] sh_q, sh_d;
    logic [9:0] rdata_q, rdata_d;
    logic       arb, g0, g1, rd_smp, rd_last, wr_win;

    always_comb begin
        arb     = cnt_q == 6'd39;
        // nxt_q names the requester favoured when both ask
        g0      = arb && req0 && (!req1 || !nxt_q);
        g1      = arb && req1 && (!req0 || nxt_q);
        cnt_d   = arb ? 6'd0 : cnt_q + 6'd1;
        busy_d  = arb ? (g0 || g1) : busy_q;
        cmd_d   = g0 ? cmd0 : g1 ? cmd1 : cmd_q;
        own_d   = (g0 || g1) ? g1 : own_q;
        nxt_d   = (g0 || g1) ? g0 : nxt_q;
        rd_smp  = busy_q && cnt_q[0] && cnt_q >= 6'd17 && cnt_q <= 6'd35;
        rd_last = rd_smp && cnt_q == 6'd35;
        sh_d    = rd_smp ? {sh_q[7:0], dq_in} : sh_q;
        // rdata only moves once the last bit arrives, so it is stable during the shift
        rdata_d = rd_last ? {sh_q, dq_in} : rdata_q;
        rid_d   = rd_last ? own_q : rid_q;
        wr_win  = busy_q && cnt_q >= 6'd2 && cnt_q <= 6'd15;
    end

    // within the write window cnt[3:1] runs 1..7, so its complement picks bits 6..0
    assign dq_out  = wr_win && cmd_q[~cnt_q[3:1]];
    assign count40 = cnt_q;
    assign ack0    = g0;
    assign ack1    = g1;
    assign busy    = busy_q;
    assign rvalid  = busy_q && cnt_q == 6'd36;
    assign rdata   = rdata_q;
    assign rid     = rid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            own_q   <= 1'b0;
            nxt_q   <= 1'b0;
            cmd_q   <= '0;
            sh_q    <= '0;
            rdata_q <= '0;
            rid_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            own_q   <= own_d;
            nxt_q   <= nxt_d;
            cmd_q   <= cmd_d;
            sh_q    <= sh_d;
            rdata_q <= rdata_d;
            rid_q   <= rid_d;
        end
    end
endmodule

// File: tb/tb_serial_frame_sched.sv
// tb_serial_frame_sched: scoreboard bench with a frame-level reference model
module tb_serial_frame_sched;
    logic       clk = 0, rst_n = 0, req0 = 0, req1 = 0, dq_in = 0;
    logic [6:0] cmd0 = 0, cmd1 = 0;
    logic [5:0] count40;
    logic       dq_out, ack0, ack1, busy, rvalid, rid;
    logic [9:0] rdata;

    int vec = 0, miss = 0;
    int mcnt = 0;
    bit mbusy = 0, mown = 0, mnext = 0, mg0 = 0, mg1 = 0, mrid = 0;
    logic [6:0] mcmd = 0;
    logic [9:0] mdata = 0, mrdata = 0;
    bit ovr_en = 0;
    logic [9:0] ovr_data = 0;
    logic [10:0] sbq[$];

    serial_frame_sched dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
        .dq_in(dq_in), .count40(count40), .dq_out(dq_out), .ack0(ack0), .ack1(ack1),
        .busy(busy), .rdata(rdata), .rvalid(rvalid), .rid(rid)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, int act, int exp);
        vec++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endfunction

    // frame-level model: arbitration at 39, read word captured at end of slot 35
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt = 0; mbusy = 0; mnext = 0; mg0 = 0; mg1 = 0;
            mrdata = 0; mrid = 0; mcmd = 0;
            sbq.delete();
        end else begin
            mg0 = 0; mg1 = 0;
            if (mbusy && mcnt == 35) begin mrdata = mdata; mrid = mown; end
            if (mcnt == 39) begin
                if (req0 && req1) begin mg0 = !mnext; mg1 = mnext; end
                else begin mg0 = req0; mg1 = req1; end
                mbusy = mg0 || mg1;
                if (mbusy) begin
                    mown  = mg1;
                    mnext = mg0;
                    mcmd  = mg1 ? cmd1 : cmd0;
                    mdata = ovr_en ? ovr_data : 10'($urandom);
                    sbq.push_back({mown, mdata});
                end
                mcnt = 0;
            end else mcnt++;
        end
    end

    // target: returns the frame's read word on odd slots 17..35, noise elsewhere
    always @(posedge clk) begin
        #1;
        dq_in = (mbusy && mcnt >= 17 && mcnt <= 35 && mcnt % 2 == 1) ? mdata[9 - (mcnt - 17) / 2] : 1'($urandom);
    end

    always @(negedge clk) begin
        logic [10:0] e;
        chk("count40", count40, mcnt);
        chk("busy", busy, mbusy);
        chk("dq_out", dq_out, (mbusy && mcnt >= 2 && mcnt <= 15) ? mcmd[6 - (mcnt - 2) / 2] : 0);
        chk("ack0", ack0, mcnt == 39 && req0 && (!req1 || !mnext));
        chk("ack1", ack1, mcnt == 39 && req1 && (!req0 || mnext));
        chk("rvalid", rvalid, mbusy && mcnt == 36);
        chk("rdata", rdata, mrdata);
        chk("rid", rid, mrid);
        if (rvalid) begin
            if (sbq.size() == 0) begin
                vec++; miss++;
                $display("FAIL sb: rvalid with rdata %0h but no pending transaction at %0t", rdata, $time);
            end else begin
                e = sbq.pop_front();
                chk("sb_rdata", rdata, e[9:0]);
                chk("sb_rid", rid, e[10]);
            end
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic wait_cnt(int v);
        for (int i = 0; i < 45; i++) begin
            step;
            if (mcnt == v) return;
        end
        chk("timeout", mcnt, v);
    endtask

    initial begin
        logic [6:0] pat;
        pat = 7'b1010011;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        // contention from reset: 0,1,0,1
        req0 = 1; req1 = 1; cmd0 = 7'h15; cmd1 = 7'h6a;
        for (int f = 0; f < 4; f++) begin
            wait_cnt(39);
            #1;
            chk("cont_ack0", ack0, f % 2 == 0);
            chk("cont_ack1", ack1, f % 2 == 1);
        end
        step; req0 = 0; req1 = 0;
        // idle frame follows the last contention frame
        wait_cnt(39);
        wait_cnt(20);
        chk("idle_busy", busy, 0);
        // single directed request
        wait_cnt(10);
        req0 = 1; cmd0 = pat; ovr_en = 1; ovr_data = 10'b1100110101;
        wait_cnt(39);
        #1 chk("single_ack0", ack0, 1);
        step; req0 = 0; ovr_en = 0;
        wait_cnt(2);
        for (int i = 0; i < 14; i++) begin
            #1 chk("single_dq", dq_out, pat[6 - i / 2]);
            step;
        end
        wait_cnt(36);
        #1;
        chk("single_rvalid", rvalid, 1);
        chk("single_rdata", rdata, 10'h335);
        chk("single_rid", rid, 0);
        // late requests
        wait_cnt(39);
        req1 = 1; cmd1 = 7'h4c;
        #1 chk("late39_ack1", ack1, 1);
        step; req1 = 0;
        wait_cnt(0);
        req1 = 1;
        #1 chk("late0_ack1", ack1, 0);
        wait_cnt(39);
        #1 chk("late0_next_ack1", ack1, 1);
        step; req1 = 0;
        // reset in the middle of the read phase
        req0 = 1; cmd0 = 7'($urandom);
        wait_cnt(39);
        step; req0 = 0;
        wait_cnt(25);
        #2 rst_n = 0;
        #1;
        chk("rst_count40", count40, 0);
        chk("rst_dq_out", dq_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rid", rid, 0);
        chk("rst_ack", {ack0, ack1}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1; req0 = 1;
        repeat (39) step;
        #1;
        chk("rel_count40", count40, 39);
        chk("rel_ack0", ack0, 1);
        step; req0 = 0;
        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            step;
            if (mg0) req0 = 0;
            else if (!req0 && $urandom_range(15) == 0) begin req0 = 1; cmd0 = 7'($urandom); end
            else if (req0 && $urandom_range(63) == 0) req0 = 0;
            if (mg1) req1 = 0;
            else if (!req1 && $urandom_range(15) == 0) begin req1 = 1; cmd1 = 7'($urandom); end
            else if (req1 && $urandom_range(63) == 0) req1 = 0;
        end
        req0 = 0; req1 = 0;
        repeat (90) step;
        chk("sb_drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
